// File: rtl/elevator_pkg.sv
// elevator_pkg: shared encodings for the elevator motor/buzzer driver.
// Holds FSM state codes, {M,D} motor/direction codes and {P,W} speed codes.
// Also provides the speed-code to high-cycle-count helper used by the PWM driver.
package elevator_pkg;

  // FSM state encoding
  localparam logic [1:0] ST_OFF  = 2'd0;
  localparam logic [1:0] ST_DEAD = 2'd1;
  localparam logic [1:0] ST_RUN  = 2'd2;

  // {M,D}: motor select and direction
  localparam logic [1:0] HOIST_DN   = 2'b00;
  localparam logic [1:0] HOIST_UP   = 2'b01;
  localparam logic [1:0] DOOR_CLOSE = 2'b10;
  localparam logic [1:0] DOOR_OPEN  = 2'b11;

  // {P,W}: speed code
  localparam logic [1:0] SPD_OFF  = 2'b00;
  localparam logic [1:0] SPD_LOW  = 2'b01;
  localparam logic [1:0] SPD_MID  = 2'b10;
  localparam logic [1:0] SPD_HIGH = 2'b11;

  // High cycles per PWM period for a speed code (integer division)
  function automatic int duty_cycles(input logic [1:0] pw, input int period);
    case (pw)
      SPD_LOW:  return period / 4;
      SPD_MID:  return period / 2;
      SPD_HIGH: return (3 * period) / 4;
      default:  return 0;
    endcase
  endfunction

endpackage

// File: rtl/elev_buzzer.sv
// elev_buzzer: BUZ_LEN-cycle square-wave burst, BUZ_DIV-cycle half period, starts high, ends low.
// Latency: BUZ goes high on the edge that samples trigger high; a trigger mid-burst restarts it.
// Backpressure: none; trigger is a level sampled every cycle, BUZ is a flop output.
module elev_buzzer #(
  parameter int BUZ_DIV = 50,
  parameter int BUZ_LEN = 1000
) (
  input  logic Clk,
  input  logic Reset,
  input  logic trigger,
  output logic BUZ
);

  localparam int DIV_W = (BUZ_DIV > 1) ? $clog2(BUZ_DIV) : 1;
  localparam int LEN_W = (BUZ_LEN > 1) ? $clog2(BUZ_LEN) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(BUZ_DIV - 1);
  localparam logic [LEN_W-1:0] LEN_LAST = LEN_W'(BUZ_LEN - 1);

  logic             active_q, active_d;
  logic             buz_q, buz_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [LEN_W-1:0] len_q, len_d;

  // Burst sequencing: trigger wins over a running burst so a new request restarts it
  always_comb begin
    active_d = active_q;
    buz_d    = buz_q;
    div_d    = div_q;
    len_d    = len_q;
    if (trigger) begin
      active_d = 1'b1;
      buz_d    = 1'b1;
      div_d    = '0;
      len_d    = '0;
    end else if (active_q) begin
      if (len_q == LEN_LAST) begin
        active_d = 1'b0;
        buz_d    = 1'b0;
        div_d    = '0;
        len_d    = '0;
      end else begin
        len_d = len_q + LEN_W'(1);
        if (div_q == DIV_LAST) begin
          div_d = '0;
          buz_d = ~buz_q;
        end else begin
          div_d = div_q + DIV_W'(1);
        end
      end
    end
  end

  // Burst state registers, cleared asynchronously so BUZ drops the moment Reset rises
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      active_q <= 1'b0;
      buz_q    <= 1'b0;
      div_q    <= '0;
      len_q    <= '0;
    end else begin
      active_q <= active_d;
      buz_q    <= buz_d;
      div_q    <= div_d;
      len_q    <= len_d;
    end
  end

  assign BUZ = buz_q;

endmodule

// File: rtl/motor_pwm_driver.sv
// motor_pwm_driver: hoist/door H-bridge PWM driver with break-before-make dead time; buzzer under BUZZER_EN.
// Latency: M/D/P/W/S registered once; drives/BUSY react on the following edge (all outputs are flops).
// Backpressure: none; BUSY is high while the all-off dead time runs, commands are sampled every cycle.
module motor_pwm_driver
  import elevator_pkg::*;
#(
  parameter int PERIOD   = 100,
  parameter int DEADTIME = 8,
  parameter int BUZ_DIV  = 50,
  parameter int BUZ_LEN  = 1000
) (
  input  logic Clk,
  input  logic Reset,
  input  logic M,
  input  logic D,
  input  logic P,
  input  logic W,
  input  logic S,
  output logic M0_UP,
  output logic M0_DN,
  output logic M1_OPEN,
  output logic M1_CLOSE,
  output logic BUZ,
  output logic BUSY
);

  localparam int CNT_W  = $clog2(PERIOD);
  localparam int DEAD_W = (DEADTIME > 1) ? $clog2(DEADTIME) : 1;
  localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(PERIOD - 1);
  localparam logic [DEAD_W-1:0] DEAD_LAST = DEAD_W'(DEADTIME - 1);

  logic m_q, d_q, p_q, w_q;
  logic [3:0] cmd_prev_q;

  logic [1:0]        state_q, state_d;
  logic [DEAD_W-1:0] dead_q, dead_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [CNT_W-1:0]  thr_q, thr_d;
  logic [1:0]        md_run_q, md_run_d;

  logic up_q, dn_q, open_q, close_q, busy_q;

  logic [1:0]       md_cmd, pw_cmd;
  logic [3:0]       cmd;
  logic             cmd_active;
  logic [CNT_W-1:0] thr_cmd;
  logic             drive_on;

  assign md_cmd     = {m_q, d_q};
  assign pw_cmd     = {p_q, w_q};
  assign cmd        = {md_cmd, pw_cmd};
  assign cmd_active = (pw_cmd != SPD_OFF);
  assign thr_cmd    = CNT_W'(duty_cycles(pw_cmd, PERIOD));

  // Sample the command inputs once; every decision below uses these copies
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      m_q        <= 1'b0;
      d_q        <= 1'b0;
      p_q        <= 1'b0;
      w_q        <= 1'b0;
      cmd_prev_q <= '0;
    end else begin
      m_q        <= M;
      d_q        <= D;
      p_q        <= P;
      w_q        <= W;
      cmd_prev_q <= cmd;
    end
  end

  // Next-state: direction/motor changes and stops always pass through DEAD; speed-only
  // changes in RUN wait for the period wrap so a period is never cut short
  always_comb begin
    state_d  = state_q;
    dead_d   = dead_q;
    cnt_d    = cnt_q;
    thr_d    = thr_q;
    md_run_d = md_run_q;
    case (state_q)
      ST_OFF: begin
        if (cmd_active) begin
          state_d = ST_DEAD;
          dead_d  = '0;
        end
      end
      ST_DEAD: begin
        if (cmd != cmd_prev_q) begin
          dead_d = '0;
        end else if (dead_q == DEAD_LAST) begin
          dead_d = '0;
          if (cmd_active) begin
            state_d  = ST_RUN;
            cnt_d    = '0;
            thr_d    = thr_cmd;
            md_run_d = md_cmd;
          end else begin
            state_d = ST_OFF;
          end
        end else begin
          dead_d = dead_q + DEAD_W'(1);
        end
      end
      ST_RUN: begin
        if ((md_cmd != md_run_q) || !cmd_active) begin
          state_d = ST_DEAD;
          dead_d  = '0;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          cnt_d = '0;
          thr_d = thr_cmd;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = ST_OFF;
        dead_d  = '0;
        cnt_d   = '0;
      end
    endcase
  end

  // Outputs are decoded from next-state so they leave flops in step with the FSM;
  // only the latched {M,D} selects a drive, which keeps the four drives one-hot
  assign drive_on = (state_d == ST_RUN) && (cnt_d < thr_d);

  // FSM, counters, latched command and output flops
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q  <= ST_OFF;
      dead_q   <= '0;
      cnt_q    <= '0;
      thr_q    <= '0;
      md_run_q <= HOIST_DN;
      up_q     <= 1'b0;
      dn_q     <= 1'b0;
      open_q   <= 1'b0;
      close_q  <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      dead_q   <= dead_d;
      cnt_q    <= cnt_d;
      thr_q    <= thr_d;
      md_run_q <= md_run_d;
      up_q     <= drive_on && (md_run_d == HOIST_UP);
      dn_q     <= drive_on && (md_run_d == HOIST_DN);
      open_q   <= drive_on && (md_run_d == DOOR_OPEN);
      close_q  <= drive_on && (md_run_d == DOOR_CLOSE);
      busy_q   <= (state_d == ST_DEAD);
    end
  end

  assign M0_UP    = up_q;
  assign M0_DN    = dn_q;
  assign M1_OPEN  = open_q;
  assign M1_CLOSE = close_q;
  assign BUSY     = busy_q;

`ifdef BUZZER_EN
  logic s_q;

  // Register the buzzer request alongside the motor command
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      s_q <= 1'b0;
    end else begin
      s_q <= S;
    end
  end

  elev_buzzer #(
    .BUZ_DIV(BUZ_DIV),
    .BUZ_LEN(BUZ_LEN)
  ) u_buzzer (
    .Clk    (Clk),
    .Reset  (Reset),
    .trigger(s_q),
    .BUZ    (BUZ)
  );
`else
  // S and the buzzer parameters have no consumer in this build
  logic unused_buz;
  assign unused_buz = S | (BUZ_DIV != BUZ_LEN);
  assign BUZ        = 1'b0;
`endif

endmodule

// File: tb/tb_motor_pwm_driver.sv
// tb_motor_pwm_driver: scenario bench for motor_pwm_driver at default parameters.
// Every output is traced per cycle; expected high-cycle counts over windows are queued
// when stimulus is applied and compared once the window has been observed.
module tb_motor_pwm_driver;

  localparam logic [5:0] M_UP    = 6'b000001;
  localparam logic [5:0] M_DN    = 6'b000010;
  localparam logic [5:0] M_OPEN  = 6'b000100;
  localparam logic [5:0] M_CLOSE = 6'b001000;
  localparam logic [5:0] M_BUSY  = 6'b010000;
  localparam logic [5:0] M_BUZ   = 6'b100000;
  localparam logic [5:0] M_NOUP  = 6'b001110;
  localparam logic [5:0] M_DRV   = 6'b001111;
  localparam logic [5:0] M_ALL   = 6'b111111;

  logic Clk = 1'b0;
  logic Reset = 1'b1;
  logic M = 1'b0, D = 1'b0, P = 1'b0, W = 1'b0, S = 1'b0;
  logic M0_UP, M0_DN, M1_OPEN, M1_CLOSE, BUZ, BUSY;
  logic [5:0] vec;

  int cyc = 0;
  int n_cmp = 0;
  int n_bad = 0;
  int overlap = 0;
  logic [5:0] trace [0:8191];

  typedef struct {
    string      tag;
    int         t_from;
    int         t_to;
    logic [5:0] mask;
    int         exp;
  } win_t;
  win_t sb_q[$];

  assign vec = {BUZ, BUSY, M1_CLOSE, M1_OPEN, M0_DN, M0_UP};

  motor_pwm_driver #(
    .PERIOD  (100),
    .DEADTIME(8),
    .BUZ_DIV (50),
    .BUZ_LEN (1000)
  ) dut (
    .Clk     (Clk),
    .Reset   (Reset),
    .M       (M),
    .D       (D),
    .P       (P),
    .W       (W),
    .S       (S),
    .M0_UP   (M0_UP),
    .M0_DN   (M0_DN),
    .M1_OPEN (M1_OPEN),
    .M1_CLOSE(M1_CLOSE),
    .BUZ     (BUZ),
    .BUSY    (BUSY)
  );

  always #5 Clk = ~Clk;

  always @(posedge Clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input int obs, input int exp);
    n_cmp++;
    if (obs != exp) begin
      n_bad++;
      $display("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int count_hits(input int t_from, input int t_to, input logic [5:0] mask);
    int n = 0;
    for (int i = t_from; i < t_to; i++) begin
      if ((trace[i] & mask) != 6'd0) n++;
    end
    return n;
  endfunction

  task automatic exp_win(input string tag, input int t_from, input int t_to,
                         input logic [5:0] mask, input int exp);
    win_t e;
    e.tag = tag; e.t_from = t_from; e.t_to = t_to; e.mask = mask; e.exp = exp;
    sb_q.push_back(e);
  endtask

  // Advance to just after the rising edge that brings the cycle counter to c
  task automatic go_to(input int c);
    while (cyc < c) begin
      @(posedge Clk);
      #1;
    end
  endtask

  task automatic drive(input logic m, input logic d, input logic p, input logic w);
    M = m; D = d; P = p; W = w;
  endtask

  // Trace outputs mid-cycle, watch drive exclusivity, retire completed windows
  always @(negedge Clk) begin : monitor
    int i;
    trace[cyc] = vec;
    if ($countones(vec[3:0]) > 1) overlap++;
    i = 0;
    while (i < sb_q.size()) begin
      if (sb_q[i].t_to <= cyc) begin
        chk(sb_q[i].tag, count_hits(sb_q[i].t_from, sb_q[i].t_to, sb_q[i].mask), sb_q[i].exp);
        sb_q.delete(i);
      end else begin
        i++;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    go_to(3);
    chk("reset_outputs", int'(vec), 0);
    go_to(5);
    Reset = 1'b0;
`ifndef BUZZER_EN
    exp_win("buz_disabled", 6, 4400, M_BUZ, 0);
`endif

    // Hoist up at 50%
    go_to(10);
    drive(1'b0, 1'b1, 1'b1, 1'b0);
    exp_win("a_busy_pre", 10, 12, M_BUSY, 0);
    exp_win("a_busy_len", 12, 20, M_BUSY, 8);
    exp_win("a_busy_after", 20, 530, M_BUSY, 0);
    exp_win("a_up_hi0", 20, 70, M_UP, 50);
    exp_win("a_up_lo0", 70, 120, M_UP, 0);
    exp_win("a_up_p1", 120, 220, M_UP, 50);
    exp_win("a_up_p2", 220, 320, M_UP, 50);
    exp_win("a_others", 10, 530, M_NOUP, 0);

    // Speed-only change to 75% mid-period
    go_to(348);
    drive(1'b0, 1'b1, 1'b1, 1'b1);
    exp_win("b_cur_hi", 320, 370, M_UP, 50);
    exp_win("b_cur_per", 320, 420, M_UP, 50);
    exp_win("b_next_hi", 420, 495, M_UP, 75);
    exp_win("b_next_lo", 495, 520, M_UP, 0);

    // Direction reversal to hoist down
    go_to(528);
    drive(1'b0, 1'b0, 1'b1, 1'b1);
    exp_win("c_up_before", 520, 530, M_UP, 10);
    exp_win("c_up_after", 530, 1100, M_UP, 0);
    exp_win("c_busy_len", 530, 538, M_BUSY, 8);
    exp_win("c_busy_after", 538, 742, M_BUSY, 0);
    exp_win("c_dn_dead", 520, 538, M_DN, 0);
    exp_win("c_dn_hi0", 538, 613, M_DN, 75);
    exp_win("c_dn_lo0", 613, 638, M_DN, 0);
    exp_win("c_dn_p1", 638, 738, M_DN, 75);

    // Door open at 25%, then stop
    go_to(740);
    drive(1'b1, 1'b1, 1'b0, 1'b1);
    exp_win("d_busy_len", 742, 750, M_BUSY, 8);
    exp_win("d_busy_run", 750, 960, M_BUSY, 0);
    exp_win("d_open_hi0", 750, 775, M_OPEN, 25);
    exp_win("d_open_lo0", 775, 850, M_OPEN, 0);
    exp_win("d_open_p1", 850, 950, M_OPEN, 25);
    exp_win("d_dn_off", 742, 1100, M_DN, 0);
    go_to(958);
    drive(1'b1, 1'b1, 1'b0, 1'b0);
    exp_win("d_open_last", 950, 960, M_OPEN, 10);
    exp_win("d_stop_busy", 960, 968, M_BUSY, 8);
    exp_win("d_off_busy", 968, 1102, M_BUSY, 0);
    exp_win("d_off_drv", 960, 1100, M_DRV, 0);

    // Command change during dead time restarts it
    go_to(1100);
    drive(1'b0, 1'b0, 1'b1, 1'b1);
    go_to(1105);
    drive(1'b0, 1'b1, 1'b1, 1'b1);
    exp_win("e_busy_restart", 1102, 1115, M_BUSY, 13);
    exp_win("e_busy_after", 1115, 1215, M_BUSY, 0);
    exp_win("e_up_hi0", 1115, 1190, M_UP, 75);
    exp_win("e_up_lo0", 1190, 1215, M_UP, 0);
    exp_win("e_dn_never", 1100, 1215, M_DN, 0);

`ifdef BUZZER_EN
    // Single buzzer burst
    go_to(1200);
    S = 1'b1;
    exp_win("buz_pre", 1190, 1202, M_BUZ, 0);
    exp_win("buz_first_hi", 1202, 1252, M_BUZ, 50);
    exp_win("buz_first_lo", 1252, 1302, M_BUZ, 0);
    exp_win("buz_burst", 1202, 2202, M_BUZ, 500);
    exp_win("buz_end", 2202, 2300, M_BUZ, 0);
    go_to(1201);
    S = 1'b0;

    // Burst extended by a second request
    go_to(2300);
    S = 1'b1;
    exp_win("buz2_part1", 2302, 2802, M_BUZ, 250);
    exp_win("buz2_restart_hi", 2802, 2852, M_BUZ, 50);
    exp_win("buz2_part2", 2802, 3802, M_BUZ, 500);
    exp_win("buz2_end", 3802, 3900, M_BUZ, 0);
    go_to(2301);
    S = 1'b0;
    go_to(2800);
    S = 1'b1;
    go_to(2801);
    S = 1'b0;
`endif

    go_to(3900);
    drive(1'b0, 1'b1, 1'b0, 1'b0);

    // Reset during RUN and during a burst
    go_to(4000);
    drive(1'b1, 1'b0, 1'b1, 1'b1);
    S = 1'b1;
    exp_win("f_busy_len", 4002, 4010, M_BUSY, 8);
    exp_win("f_close_hi", 4010, 4020, M_CLOSE, 10);
    go_to(4001);
    S = 1'b0;
    go_to(4020);
    chk("f_close_pre_rst", int'(M1_CLOSE), 1);
`ifdef BUZZER_EN
    chk("f_buz_pre_rst", int'(BUZ), 1);
`endif
    Reset = 1'b1;
    #1;
    chk("f_rst_async", int'(vec), 0);
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    exp_win("f_idle_after_rst", 4021, 4200, M_ALL, 0);
    go_to(4023);
    Reset = 1'b0;
    go_to(4200);
    drive(1'b1, 1'b0, 1'b0, 1'b1);
    exp_win("f_new_busy", 4202, 4210, M_BUSY, 8);
    exp_win("f_new_close_hi", 4210, 4235, M_CLOSE, 25);
    exp_win("f_new_close_lo", 4235, 4310, M_CLOSE, 0);
    exp_win("f_new_close_p1", 4310, 4335, M_CLOSE, 25);

    go_to(4400);
    for (int g = 0; g < 200 && sb_q.size() != 0; g++) @(negedge Clk);
    chk("scoreboard_drained", sb_q.size(), 0);
    chk("drive_overlap", overlap, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
